i4001_rom: RTL

- Behavioural model of one 4001 256x8 mask-ROM with a 4-bit I/O port.
- Sits directly downstream of the i4004 CPU and consumes its bus-cycle outputs: sync_pad, cmrom_pad, data_out, data_dir.
- Tracks the 8-phase instruction cycle and returns instruction bytes on the shared 4-bit bus when selected.
- Executes SRC/WRR/RDR against its port.
- Multiple instances (distinct CHIP_ID) form the program store of an MCS-4 system.

---
 rtl/i4001_rom.sv | 132 +++++++++++++
 1 files changed

// File: rtl/i4001_rom.sv
// 4001 256x8 mask ROM with 4-bit I/O port; follows the 4004 eight-phase bus cycle.
// Define I4001_IO_PORT_EN to build the SRC/WRR/RDR port logic; otherwise port_out is tied low.
module i4001_rom #(
  parameter logic [3:0]    CHIP_ID  = 4'h0,
  // Mask image as an elaborated constant: byte n lives at bits [8n+7:8n].
  parameter logic [2047:0] ROM_INIT = '0
) (
  input  logic       sysclk,
  input  logic       poc_n,
  input  logic       clk1,
  input  logic       clk2,
  input  logic       sync,
  input  logic       cmrom,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_dir,
  input  logic [3:0] port_in,
  output logic [3:0] port_out
);

  typedef enum logic [2:0] {
    PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
  } phase_t;

  phase_t      phase, phase_nxt;
  logic        clk2_q;
  logic        step;
  logic [7:0]  addr;
  logic        selected;
  logic [3:0]  opr;
  logic [7:0]  rom_byte;
  logic [3:0]  bus_val;
  logic        drive_nxt;
  logic [3:0]  dout_nxt;

  assign step     = clk2 & ~clk2_q;
  // NOTE: the ROM is a constant, so it needs neither a reset nor a write port.
  assign rom_byte = ROM_INIT[{addr, 3'b000} +: 8];

  always_comb begin
    phase_nxt = phase;
    if (step) phase_nxt = sync ? PH_A1 : phase_t'(phase + 3'd1);
  end

  // Value on the shared bus during M1/M2: our own nibble when we are the source.
  always_comb begin
    bus_val = data_in;
    if (selected) bus_val = (phase == PH_M1) ? rom_byte[7:4] : rom_byte[3:0];
  end

`ifdef I4001_IO_PORT_EN
  logic [4:0] io_op;
  logic       src_match;
  logic       rdr_hit;

  assign rdr_hit = io_op[4] && (io_op[3:0] == 4'hA) && src_match;

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      io_op     <= 5'd0;
      src_match <= 1'b0;
      port_out  <= 4'h0;
    end else if (step) begin
      if (phase == PH_M2)
        io_op <= (cmrom && opr == 4'hE) ? {1'b1, bus_val} : 5'd0;
      if (phase == PH_X2) begin
        if (cmrom && !io_op[4]) src_match <= (data_in == CHIP_ID);
        if (io_op[4] && io_op[3:0] == 4'h2 && src_match) port_out <= data_in;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = clk1;
`else
  assign port_out = 4'h0;

  logic unused_ok;
  assign unused_ok = ^{clk1, cmrom, port_in, opr};
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    drive_nxt = 1'b0;
    dout_nxt  = data_out;
    case (phase)
      PH_M1: if (selected) begin
        drive_nxt = 1'b1;
        dout_nxt  = rom_byte[7:4];
      end
      PH_M2: if (selected) begin
        drive_nxt = 1'b1;
        dout_nxt  = rom_byte[3:0];
      end
`ifdef I4001_IO_PORT_EN
      PH_X2: if (rdr_hit) begin
        drive_nxt = 1'b1;
        dout_nxt  = port_in;
      end
`endif
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      phase    <= PH_X3;
      clk2_q   <= 1'b0;
      addr     <= 8'h00;
      selected <= 1'b0;
      opr      <= 4'h0;
      data_dir <= 1'b0;
      data_out <= 4'h0;
    end else begin
      clk2_q   <= clk2;
      phase    <= phase_nxt;
      data_dir <= drive_nxt;
      data_out <= dout_nxt;
      if (step) begin
        case (phase)
          PH_A1:   addr[3:0] <= data_in;
          PH_A2:   addr[7:4] <= data_in;
          PH_A3:   selected  <= (data_in == CHIP_ID);
          PH_M1:   opr       <= bus_val;
          default: ;
        endcase
      end
    end
  end

endmodule
